// File: rtl/mem_store_merger.sv
// Read-modify-write store merger: byte/half stores read the target word, merge the new lanes, write it back.
// Optional misalignment check enabled by defining MEM_STORE_MISALIGN_CHECK_EN.
module mem_store_merger #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_ADDR = 10,
    parameter int unsigned NB_MASK = 2
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic [NB_ADDR+1:0] i_address,
    input  logic [NB_DATA-1:0] i_dato,
    input  logic [NB_MASK-1:0] i_mascara,
    output logic               o_ready,
    output logic [NB_ADDR-1:0] o_mem_addr,
    output logic               o_mem_rd_en,
    input  logic [NB_DATA-1:0] i_mem_rd_data,
    output logic               o_mem_wr_en,
    output logic [NB_DATA-1:0] o_mem_wr_data,
    output logic               o_done,
    output logic               o_misaligned
);

    localparam logic [NB_MASK-1:0] MASK_BYTE = NB_MASK'(0);
    localparam logic [NB_MASK-1:0] MASK_HALF = NB_MASK'(1);
    localparam logic [NB_MASK-1:0] MASK_RSVD = NB_MASK'(2);
    localparam logic [NB_MASK-1:0] MASK_WORD = NB_MASK'(3);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_MERGE,
        ST_WRITE,
        ST_ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [NB_ADDR+1:0] addr_q, addr_d;
    logic [NB_MASK-1:0] mask_q, mask_d;
    logic [NB_DATA-1:0] wdata_q, wdata_d;
    logic [NB_DATA-1:0] merged_c;
    logic               ready_q, rd_en_q, wr_en_q, done_q;
    logic               word_c, bad_c;

    // Classify the incoming request: direct word write, or rejected as misaligned.
    always_comb begin
        bad_c  = 1'b0;
`ifdef MEM_STORE_MISALIGN_CHECK_EN
        word_c = (i_mascara == MASK_WORD);
        bad_c  = (i_mascara == MASK_RSVD)
              || ((i_mascara == MASK_HALF) && i_address[0])
              || ((i_mascara == MASK_WORD) && (i_address[1:0] != 2'b00));
`else
        word_c = (i_mascara == MASK_WORD) || (i_mascara == MASK_RSVD);
`endif
    end

    // Little-endian lane merge; wdata_q holds the captured store data until MERGE.
    always_comb begin
        merged_c = i_mem_rd_data;
        if (mask_q == MASK_BYTE) begin
            merged_c[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged_c[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    addr_d  = i_address;
                    mask_d  = i_mascara;
                    wdata_d = i_dato;
                    if (bad_c) begin
                        state_d = ST_ERROR;
                    end else if (word_c) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ:  state_d = ST_MERGE;
            ST_MERGE: begin
                wdata_d = merged_c;
                state_d = ST_WRITE;
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_ERROR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            mask_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b1;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
            wdata_q <= wdata_d;
            ready_q <= (state_d == ST_IDLE);
            rd_en_q <= (state_d == ST_READ);
            wr_en_q <= (state_d == ST_WRITE);
            done_q  <= (state_d == ST_WRITE) || (state_d == ST_ERROR);
        end
    end

`ifdef MEM_STORE_MISALIGN_CHECK_EN
    logic misal_q;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            misal_q <= 1'b0;
        end else begin
            misal_q <= (state_d == ST_ERROR);
        end
    end

    assign o_misaligned = misal_q;
`else
    assign o_misaligned = 1'b0;
`endif

    assign o_ready       = ready_q;
    assign o_mem_addr    = addr_q[NB_ADDR+1:2];
    assign o_mem_rd_en   = rd_en_q;
    assign o_mem_wr_en   = wr_en_q;
    assign o_mem_wr_data = wdata_q;
    assign o_done        = done_q;

endmodule

// File: tb/tb_mem_store_merger.sv
// Bench for mem_store_merger: directed table, reset-abort sequence and random stores vs. a lane-arithmetic model.
module tb_mem_store_merger;

    localparam int unsigned NB_DATA = 32;
    localparam int unsigned NB_ADDR = 10;
    localparam int unsigned NB_MASK = 2;

    logic               i_clock = 1'b0;
    logic               i_reset;
    logic               i_valid;
    logic [NB_ADDR+1:0] i_address;
    logic [NB_DATA-1:0] i_dato;
    logic [NB_MASK-1:0] i_mascara;
    logic               o_ready;
    logic [NB_ADDR-1:0] o_mem_addr;
    logic               o_mem_rd_en;
    logic [NB_DATA-1:0] i_mem_rd_data;
    logic               o_mem_wr_en;
    logic [NB_DATA-1:0] o_mem_wr_data;
    logic               o_done;
    logic               o_misaligned;

    mem_store_merger #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .NB_MASK(NB_MASK)) dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_valid       (i_valid),
        .i_address     (i_address),
        .i_dato        (i_dato),
        .i_mascara     (i_mascara),
        .o_ready       (o_ready),
        .o_mem_addr    (o_mem_addr),
        .o_mem_rd_en   (o_mem_rd_en),
        .i_mem_rd_data (i_mem_rd_data),
        .o_mem_wr_en   (o_mem_wr_en),
        .o_mem_wr_data (o_mem_wr_data),
        .o_done        (o_done),
        .o_misaligned  (o_misaligned)
    );

    always #5 i_clock = ~i_clock;

    // Synchronous memory: read data appears the cycle after o_mem_rd_en.
    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;

    always @(posedge i_clock) begin
        if (pl_en) mem[pl_idx] <= pl_val;
        if (o_mem_rd_en) i_mem_rd_data <= mem[o_mem_addr[3:0]];
        if (o_mem_wr_en) mem[o_mem_addr[3:0]] <= o_mem_wr_data;
    end

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] val);
        pl_en  = 1'b1;
        pl_idx = idx;
        pl_val = val;
        ref_mem[idx] = val;
        @(negedge i_clock);
        pl_en = 1'b0;
    endtask

    // Reference: expected write word / path from the store rules, using shifts and masks.
    function automatic void model(input logic [11:0] a, input logic [31:0] d, input logic [1:0] m,
                                  input logic [31:0] old, output logic [31:0] nw,
                                  output bit wr, output bit mis, output int lat);
        int sh;
        bit word;
`ifdef MEM_STORE_MISALIGN_CHECK_EN
        word = (m == 2'b11);
        mis  = (m == 2'b10) || (m == 2'b01 && a[0]) || (m == 2'b11 && a[1:0] != 2'b00);
`else
        word = m[1];
        mis  = 1'b0;
`endif
        nw = old;
        wr = 1'b1;
        lat = 3;
        if (mis) begin
            wr  = 1'b0;
            lat = 1;
        end else if (word) begin
            nw  = d;
            lat = 1;
        end else if (m == 2'b00) begin
            sh = 8 * int'(a[1:0]);
            nw = (old & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
        end else begin
            sh = 16 * int'(a[1]);
            nw = (old & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
        end
    endfunction

    // Issue one store from an IDLE negedge and observe it up to the following IDLE cycle.
    task automatic do_store(input string tag, input logic [11:0] addr, input logic [31:0] dato,
                            input logic [1:0] mask, input logic [31:0] exp_data,
                            input bit exp_wr, input bit exp_mis, input int exp_lat);
        int rd_n = 0, rd_k = 0, wr_n = 0, wr_k = 0, done_n = 0, done_k = 0;
        int mis_n = 0, addr_bad = 0, ready_bad = 0;
        logic [31:0] wr_d = '0;
        chk({tag, " ready_before"}, 32'(o_ready), 32'd1);
        i_valid   = 1'b1;
        i_address = addr;
        i_dato    = dato;
        i_mascara = mask;
        for (int k = 1; k <= exp_lat + 1; k++) begin
            @(posedge i_clock);
            #1;
            if (k == 1) begin
                i_address = 12'($urandom);
                i_dato    = $urandom;
                i_mascara = 2'($urandom);
            end else begin
                i_valid = 1'b0;
            end
            @(negedge i_clock);
            if (o_mem_rd_en) begin rd_n++; rd_k = k; end
            if (o_mem_wr_en) begin wr_n++; wr_k = k; wr_d = o_mem_wr_data; end
            if (o_done) begin done_n++; done_k = k; end
            if (o_misaligned) mis_n++;
            if (o_mem_addr !== addr[11:2]) addr_bad++;
            if (k <= exp_lat && o_ready) ready_bad++;
        end
        chk({tag, " rd_count"}, 32'(rd_n), (exp_lat == 3) ? 32'd1 : 32'd0);
        chk({tag, " rd_cycle"}, 32'(rd_k), (exp_lat == 3) ? 32'd1 : 32'd0);
        chk({tag, " wr_count"}, 32'(wr_n), exp_wr ? 32'd1 : 32'd0);
        chk({tag, " wr_cycle"}, 32'(wr_k), exp_wr ? 32'(exp_lat) : 32'd0);
        if (exp_wr) chk({tag, " wr_data"}, wr_d, exp_data);
        chk({tag, " done_count"}, 32'(done_n), 32'd1);
        chk({tag, " done_cycle"}, 32'(done_k), 32'(exp_lat));
        chk({tag, " misaligned"}, 32'(mis_n), exp_mis ? 32'd1 : 32'd0);
        chk({tag, " mem_addr_hold"}, 32'(addr_bad), 32'd0);
        chk({tag, " ready_low_busy"}, 32'(ready_bad), 32'd0);
        chk({tag, " ready_after"}, 32'(o_ready), 32'd1);
        if (exp_wr) ref_mem[addr[5:2]] = exp_data;
    endtask

    typedef struct {
        string       name;
        logic [11:0] addr;
        logic [31:0] dato;
        logic [1:0]  mask;
        logic [31:0] exp_data;
        bit          exp_wr;
        bit          exp_mis;
        int          exp_lat;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [11:0] ra;
        logic [31:0] rd, nw;
        logic [1:0]  rm;
        bit          wr, mis;
        int          lat;

        tbl[0] = '{"byte_0x12",  12'h012, 32'h000000AB, 2'b00, 32'h11AB3344, 1'b1, 1'b0, 3};
        tbl[1] = '{"half_0x12",  12'h012, 32'h0000BEEF, 2'b01, 32'hBEEF3344, 1'b1, 1'b0, 3};
        tbl[2] = '{"half_0x10",  12'h010, 32'h0000BEEF, 2'b01, 32'h1122BEEF, 1'b1, 1'b0, 3};
        tbl[3] = '{"word_0x10",  12'h010, 32'hCAFEF00D, 2'b11, 32'hCAFEF00D, 1'b1, 1'b0, 1};
        tbl[4] = '{"byte_0x13",  12'h013, 32'h123456CD, 2'b00, 32'hCD223344, 1'b1, 1'b0, 3};
`ifdef MEM_STORE_MISALIGN_CHECK_EN
        tbl[5] = '{"half_0x11",  12'h011, 32'h0000BEEF, 2'b01, 32'h0,        1'b0, 1'b1, 1};
        tbl[6] = '{"word_0x12",  12'h012, 32'hCAFEF00D, 2'b11, 32'h0,        1'b0, 1'b1, 1};
        tbl[7] = '{"rsvd_0x10",  12'h010, 32'h87654321, 2'b10, 32'h0,        1'b0, 1'b1, 1};
`else
        tbl[5] = '{"half_0x11",  12'h011, 32'h0000BEEF, 2'b01, 32'h1122BEEF, 1'b1, 1'b0, 3};
        tbl[6] = '{"word_0x12",  12'h012, 32'hCAFEF00D, 2'b11, 32'hCAFEF00D, 1'b1, 1'b0, 1};
        tbl[7] = '{"rsvd_0x10",  12'h010, 32'h87654321, 2'b10, 32'h87654321, 1'b1, 1'b0, 1};
`endif

        i_reset   = 1'b1;
        i_valid   = 1'b0;
        i_address = '0;
        i_dato    = '0;
        i_mascara = '0;
        repeat (3) @(negedge i_clock);
        chk("reset ready", 32'(o_ready), 32'd1);
        chk("reset rd_en", 32'(o_mem_rd_en), 32'd0);
        chk("reset wr_en", 32'(o_mem_wr_en), 32'd0);
        chk("reset done", 32'(o_done), 32'd0);
        chk("reset misaligned", 32'(o_misaligned), 32'd0);
        chk("reset mem_addr", 32'(o_mem_addr), 32'd0);
        i_reset = 1'b0;
        @(negedge i_clock);

        for (int i = 0; i < 16; i++) preload(4'(i), $urandom);

        // Directed table against word 4 = 0x11223344.
        for (int i = 0; i < 8; i++) begin
            preload(4'd4, 32'h11223344);
            do_store(tbl[i].name, tbl[i].addr, tbl[i].dato, tbl[i].mask,
                     tbl[i].exp_data, tbl[i].exp_wr, tbl[i].exp_mis, tbl[i].exp_lat);
        end

        // Reset asserted while in MERGE must abort the write and return to IDLE at once.
        preload(4'd4, 32'h11223344);
        i_valid   = 1'b1;
        i_address = 12'h012;
        i_dato    = 32'h000000AB;
        i_mascara = 2'b00;
        @(posedge i_clock);
        #1 i_valid = 1'b0;
        @(posedge i_clock);
        @(negedge i_clock);
        i_reset = 1'b1;
        #1;
        chk("abort ready_immediate", 32'(o_ready), 32'd1);
        chk("abort wr_en_immediate", 32'(o_mem_wr_en), 32'd0);
        chk("abort mem_addr_cleared", 32'(o_mem_addr), 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge i_clock);
            chk("abort wr_en_in_reset", 32'(o_mem_wr_en), 32'd0);
        end
        i_reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clock);
            chk("abort wr_en_after", 32'(o_mem_wr_en), 32'd0);
            chk("abort ready_after", 32'(o_ready), 32'd1);
        end
        do_store("after_abort", 12'h012, 32'h000000AB, 2'b00, 32'h11AB3344, 1'b1, 1'b0, 3);

        // Random back-to-back stores against the reference model.
        for (int n = 0; n < 200; n++) begin
            ra = {6'b0, 4'($urandom_range(0, 15)), 2'($urandom)};
            rd = $urandom;
            rm = 2'($urandom);
            model(ra, rd, rm, ref_mem[ra[5:2]], nw, wr, mis, lat);
            do_store("random", ra, rd, rm, nw, wr, mis, lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
